// File: rtl/memory_sequencer.sv
// Copies ROM[0..LAST_ADDR] into RAM through an XOR mask, then re-reads both
// memories and counts words where RAM differs from the masked ROM word.
module memory_sequencer #(
  parameter logic [7:0] PATTERN_XOR = 8'h00,
  parameter logic [2:0] LAST_ADDR   = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dataBus,
  output logic [2:0] adressBus,
  output logic       RW,
  output logic       CS,
  output logic [7:0] dataInRAM,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] errCount
);

  typedef enum logic [2:0] {
    IDLE, RD_ROM, CAP_ROM, WR_RAM, VF_ROM, VF_CAP, VF_RAM, DONE
  } state_t;

  state_t     state;
  logic [2:0] idx;
  logic [7:0] word;
  logic       last;
  logic [3:0] err_upd;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= 4'd8) ? 4'd8 : v + 4'd1;
  endfunction

  always_comb begin
    last    = (idx == LAST_ADDR);
    err_upd = (dataBus != (word ^ PATTERN_XOR)) ? sat_inc(errCount) : errCount;
  end

  // Bus outputs are loaded on the edge that enters each state, so every
  // state's bus values are visible for the whole cycle it occupies.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 3'd0;
      adressBus <= 3'd0;
      RW        <= 1'b1;
      CS        <= 1'b1;
      dataInRAM <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      errCount  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          RW <= 1'b1;
          CS <= 1'b1;
          if (start) begin
            state     <= RD_ROM;
            idx       <= 3'd0;
            adressBus <= 3'd0;
            errCount  <= 4'd0;
            pass      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RD_ROM: state <= CAP_ROM;
        CAP_ROM: begin
          // ROM word becomes the RAM write data on the same edge it is captured
          word      <= dataBus;
          dataInRAM <= dataBus ^ PATTERN_XOR;
          CS        <= 1'b0;
          RW        <= 1'b0;
          state     <= WR_RAM;
        end
        WR_RAM: begin
          RW <= 1'b1;
          CS <= 1'b1;
          if (last) begin
            idx       <= 3'd0;
            adressBus <= 3'd0;
            state     <= VF_ROM;
          end else begin
            idx       <= idx + 3'd1;
            adressBus <= idx + 3'd1;
            state     <= RD_ROM;
          end
        end
        VF_ROM: state <= VF_CAP;
        VF_CAP: begin
          word  <= dataBus;
          CS    <= 1'b0;
          state <= VF_RAM;
        end
        VF_RAM: begin
          errCount <= err_upd;
          CS       <= 1'b1;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_upd == 4'd0);
          end else begin
            idx       <= idx + 3'd1;
            adressBus <= idx + 3'd1;
            state     <= VF_ROM;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_sequencer.sv
// Bench for memory_sequencer: two instances (mask 00 and FF) on an 8x8
// ROM/RAM model with ROM[a]=a and selectable read-fault injection.
module tb_memory_sequencer;

  localparam int NW       = 8;
  localparam int DONE_CYC = 6 * NW + 1;

  logic       clk;
  logic       rst_s   [2];
  logic       start_s [2];
  logic [7:0] bus     [2];
  logic [2:0] addr    [2];
  logic       rw      [2];
  logic       cs      [2];
  logic [7:0] din     [2];
  logic       busy    [2];
  logic       done_o  [2];
  logic       pass_o  [2];
  logic [3:0] err     [2];

  logic [7:0] rom_q [2];
  logic [7:0] ram   [2][8];
  logic [7:0] fmask [2];
  int         wr_cnt [2];
  logic [2:0] wr_a  [2][256];
  logic [7:0] wr_d  [2][256];
  int         viol  [2];
  logic       prev_rw [2];
  logic [2:0] prev_a  [2];

  int n_pass;
  int n_total;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam logic [7:0] MASK = (g == 0) ? 8'h00 : 8'hFF;

    memory_sequencer #(.PATTERN_XOR(MASK), .LAST_ADDR(3'd7)) dut (
      .clk(clk), .rst(rst_s[g]), .start(start_s[g]), .dataBus(bus[g]),
      .adressBus(addr[g]), .RW(rw[g]), .CS(cs[g]), .dataInRAM(din[g]),
      .busy(busy[g]), .done(done_o[g]), .pass(pass_o[g]), .errCount(err[g])
    );

    assign bus[g] = (cs[g] === 1'b0 && rw[g] === 1'b1 && fmask[g][addr[g]]) ? 8'h55 :
                    (cs[g] ? rom_q[g] : ram[g][addr[g]]);

    // Sampled at the edge that ends each cycle, i.e. the values held during it
    always @(posedge clk) begin
      rom_q[g] <= {5'd0, addr[g]};
      if (rw[g] === 1'b0) begin
        ram[g][addr[g]]              <= din[g];
        wr_a[g][wr_cnt[g] & 255]     <= addr[g];
        wr_d[g][wr_cnt[g] & 255]     <= din[g];
        wr_cnt[g]                    <= wr_cnt[g] + 1;
        if (cs[g] !== 1'b0) begin
          $display("FAIL monitor%0d write_with_cs: CS=%b required 0", g, cs[g]);
          viol[g] <= viol[g] + 1;
        end
        if (prev_rw[g] === 1'b0 && prev_a[g] !== addr[g]) begin
          $display("FAIL monitor%0d addr_change_during_write: %0d -> %0d", g, prev_a[g], addr[g]);
          viol[g] <= viol[g] + 1;
        end
      end
      prev_rw[g] <= rw[g];
      prev_a[g]  <= addr[g];
    end
  end

  function automatic int exp_err(input logic [7:0] faults);
    int n = 0;
    for (int a = 0; a < NW; a++) if (faults[a]) n++;
    return (n > 8) ? 8 : n;
  endfunction

  task automatic test_reset();
    for (int g = 0; g < 2; g++) begin rst_s[g] = 1'b1; start_s[g] = 1'b0; fmask[g] = 8'h00; end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_total++;
      if ({addr[g], rw[g], cs[g], din[g], busy[g], done_o[g], pass_o[g], err[g]} !==
          {3'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0})
        $display("FAIL reset%0d outputs: addr=%0d RW=%b CS=%b din=%h busy=%b done=%b pass=%b err=%0d required 0,1,1,00,0,0,0,0",
                 g, addr[g], rw[g], cs[g], din[g], busy[g], done_o[g], pass_o[g], err[g]);
      else n_pass++;
      rst_s[g] = 1'b0;
    end
    @(negedge clk);
  endtask

  // One run on instance g; start is pulsed (or toggled in cycles 5..30)
  task automatic run(input int g, input logic [7:0] faults, input bit toggle, input string name);
    logic [7:0] mask = (g == 0) ? 8'h00 : 8'hFF;
    int base, dcyc, pulses, bad, ee;
    logic busy48;
    fmask[g] = faults;
    base = wr_cnt[g];
    dcyc = -1; pulses = 0; busy48 = 1'b0;
    start_s[g] = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start_s[g] = (toggle && c >= 5 && c <= 30) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (done_o[g] === 1'b1) begin
        pulses++;
        if (dcyc < 0) dcyc = c;
      end
      if (c == 48) busy48 = busy[g];
    end
    ee = exp_err(faults);
    n_total++;
    if (dcyc !== DONE_CYC) $display("FAIL %s done_cycle: got %0d required %0d", name, dcyc, DONE_CYC);
    else n_pass++;
    n_total++;
    if (pulses !== 1) $display("FAIL %s done_pulses: got %0d required 1", name, pulses);
    else n_pass++;
    n_total++;
    if (busy48 !== 1'b1 || busy[g] !== 1'b0)
      $display("FAIL %s busy: cycle48=%b end=%b required 1,0", name, busy48, busy[g]);
    else n_pass++;
    n_total++;
    if (wr_cnt[g] - base !== NW) $display("FAIL %s write_count: got %0d required %0d", name, wr_cnt[g] - base, NW);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < NW; i++) begin
      logic [7:0] want = 8'(i) ^ mask;
      n_total++;
      if (wr_a[g][(base + i) & 255] !== 3'(i) || wr_d[g][(base + i) & 255] !== want)
        $display("FAIL %s write%0d: addr=%0d data=%h required addr=%0d data=%h",
                 name, i, wr_a[g][(base + i) & 255], wr_d[g][(base + i) & 255], i, want);
      else n_pass++;
    end
    n_total++;
    if (err[g] !== 4'(ee)) $display("FAIL %s errCount: got %0d required %0d", name, err[g], ee);
    else n_pass++;
    n_total++;
    if (pass_o[g] !== (ee == 0)) $display("FAIL %s pass: got %b required %b", name, pass_o[g], ee == 0);
    else n_pass++;
    fmask[g] = 8'h00;
  endtask

  task automatic test_basic();  run(0, 8'h00, 1'b0, "basic"); endtask
  task automatic test_mask();   run(1, 8'h00, 1'b0, "mask");  endtask
  task automatic test_fault();  run(0, 8'h08, 1'b0, "fault_addr3"); endtask
  task automatic test_start_while_busy(); run(0, 8'h00, 1'b1, "start_busy"); endtask

  task automatic test_random_faults();
    for (int it = 0; it < 6; it++) begin
      int g = (it == 0) ? 1 : int'($urandom_range(0, 1));
      logic [7:0] f = (it == 0) ? 8'hFF : 8'($urandom);
      run(g, f, 1'b0, $sformatf("rand%0d_g%0d_f%02h", it, g, f));
    end
  endtask

  task automatic test_reset_mid_run();
    int base = wr_cnt[0];
    int after, pulses = 0;
    start_s[0] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
    end
    n_total++;
    if (wr_cnt[0] - base !== 3) $display("FAIL midreset writes_before: got %0d required 3", wr_cnt[0] - base);
    else n_pass++;
    rst_s[0] = 1'b1;
    @(negedge clk);
    n_total++;
    if ({rw[0], cs[0], addr[0], busy[0], done_o[0]} !== {1'b1, 1'b1, 3'd0, 1'b0, 1'b0})
      $display("FAIL midreset outputs: RW=%b CS=%b addr=%0d busy=%b done=%b required 1,1,0,0,0",
               rw[0], cs[0], addr[0], busy[0], done_o[0]);
    else n_pass++;
    rst_s[0] = 1'b0;
    after = wr_cnt[0];
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done_o[0] === 1'b1) pulses++;
    end
    n_total++;
    if (wr_cnt[0] !== after || pulses !== 0)
      $display("FAIL midreset quiet: writes=%0d done_pulses=%0d required 0,0", wr_cnt[0] - after, pulses);
    else n_pass++;
    run(0, 8'h00, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int base = wr_cnt[0];
    int d1 = -1, d2 = -1, pulses = 0;
    start_s[0] = 1'b1;
    for (int c = 1; c <= 110; c++) begin
      @(negedge clk);
      if (c >= 99) start_s[0] = 1'b0;
      if (done_o[0] === 1'b1) begin
        pulses++;
        if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
      end
    end
    n_total++;
    if (pulses !== 2 || d1 !== DONE_CYC || d2 !== 2 * DONE_CYC + 1)
      $display("FAIL back_to_back done: pulses=%0d at %0d,%0d required 2 at %0d,%0d",
               pulses, d1, d2, DONE_CYC, 2 * DONE_CYC + 1);
    else n_pass++;
    n_total++;
    if (wr_cnt[0] - base !== 2 * NW || pass_o[0] !== 1'b1)
      $display("FAIL back_to_back result: writes=%0d pass=%b required %0d,1", wr_cnt[0] - base, pass_o[0], 2 * NW);
    else n_pass++;
  endtask

  task automatic test_monitor();
    n_total++;
    if (viol[0] + viol[1] !== 0) $display("FAIL monitor violations: got %0d required 0", viol[0] + viol[1]);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_mask();
    test_fault();
    test_start_while_busy();
    test_random_faults();
    test_reset_mid_run();
    test_back_to_back();
    test_monitor();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/memory_sequencer.md
MEMORY_SEQUENCER -- requirements
Module: memory_sequencer

Interface
REQ-001 The module SHALL have parameter PATTERN_XOR, default 8'h00, as the XOR mask applied to each ROM word before it is written to RAM.
REQ-002 The module SHALL have parameter LAST_ADDR, default 3'd7, as the highest address processed; the sweep runs from 0 to LAST_ADDR.
REQ-003 Port clk: input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 Port rst: input, 1 bit, synchronous active-high reset.
REQ-005 Port start: input, 1 bit, level-sampled request to begin a copy and verify run.
REQ-006 Port dataBus: input, 8 bits, memory read data (ROM when CS=1, RAM when CS=0).
REQ-007 Port adressBus: output, 3 bits, memory address.
REQ-008 Port RW: output, 1 bit; 1 means read, 0 means write to RAM.
REQ-009 Port CS: output, 1 bit; 1 selects ROM output, 0 selects RAM output.
REQ-010 Port dataInRAM: output, 8 bits, RAM write data.
REQ-011 Port busy: output, 1 bit, high while a run is in progress.
REQ-012 Port done: output, 1 bit, one-cycle pulse at the end of a run.
REQ-013 Port pass: output, 1 bit; 1 when the last run had zero mismatches.
REQ-014 Port errCount: output, 4 bits, mismatch count of the last run (range 0..8).

Function
REQ-015 All outputs SHALL be registered, and adressBus, RW, CS and dataInRAM SHALL update on the same clock edge.
REQ-016 The memory timing contract SHALL be:
- ROM read is synchronous: data is valid on dataBus in the cycle after the address is presented.
- RAM read and write are asynchronous and level-sensitive on RW.
REQ-017 The FSM states SHALL be IDLE, RD_ROM, CAP_ROM, WR_RAM, VF_ROM, VF_CAP, VF_RAM and DONE.
REQ-018 IDLE SHALL drive RW=1, CS=1 and busy=0; start=1 SHALL move the FSM to RD_ROM, set idx=0, clear errCount and pass, and set busy=1.
REQ-019 RD_ROM SHALL drive adressBus=idx, CS=1, RW=1, then go to CAP_ROM.
REQ-020 CAP_ROM SHALL hold the same bus values and capture dataBus into word on the exiting edge, then go to WR_RAM.
REQ-021 WR_RAM SHALL drive CS=0, RW=0, adressBus=idx and dataInRAM = word XOR PATTERN_XOR for exactly one cycle.
REQ-022 On leaving WR_RAM: if idx==LAST_ADDR, set idx=0 and go to VF_ROM; otherwise increment idx and go to RD_ROM.
REQ-023 VF_ROM and VF_CAP SHALL mirror RD_ROM and CAP_ROM, with VF_CAP capturing word.
REQ-024 VF_RAM SHALL drive CS=0, RW=1, adressBus=idx.
REQ-025 On leaving VF_RAM, errCount SHALL increment by 1 when dataBus != (word XOR PATTERN_XOR).
REQ-026 On leaving VF_RAM: if idx==LAST_ADDR, go to DONE; otherwise increment idx and go to VF_ROM.
REQ-027 DONE SHALL:
- assert done=1 for one cycle;
- set pass=(errCount==0);
- deassert busy;
- return to IDLE.
REQ-028 With LAST_ADDR=7, done SHALL be high in cycle 49 after the edge that accepted start (3 cycles per word for copy, 3 for verify, plus 1).
REQ-029 RW=0 SHALL occur only in WR_RAM, and adressBus SHALL NOT change while RW=0.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 If start is high in the IDLE cycle following DONE, a new run SHALL begin.
REQ-032 pass and errCount SHALL hold their values until the next start is accepted.
REQ-033 errCount SHALL saturate at 8 and SHALL NOT wrap.

Reset
REQ-034 When rst=1 at an edge, the block SHALL enter IDLE with adressBus=0, RW=1, CS=1, dataInRAM=0, busy=0, done=0, pass=0 and errCount=0.
REQ-035 Reset SHALL take priority over start and over any in-progress state.
REQ-036 After reset no further RAM write SHALL occur, and partially copied RAM contents are undefined.

Verification
REQ-037 Bench SHALL use the 8x8 RAM/ROM model with ROM[a]=a.
REQ-038 Scenario, basic run: PATTERN_XOR=0, single start pulse -> 8 writes of 0..7 to addresses 0..7, done at cycle 49, pass=1, errCount=0.
REQ-039 Scenario, mask: PATTERN_XOR=8'hFF -> written values 8'hFF, 8'hFE .. 8'hF8, pass=1.
REQ-040 Scenario, fault injection: force dataBus=8'h55 during VF_RAM at address 3 -> errCount=1, pass=0, done still at cycle 49.
REQ-041 Scenario, reset mid-run: rst asserted at cycle 10 -> next cycle RW=1, CS=1, adressBus=0, busy=0, no further writes; a subsequent start completes with pass=1.
REQ-042 Scenario, start while busy: start toggled during cycles 5..30 -> exactly one done pulse, at cycle 49.
REQ-043 A monitor SHALL flag any adressBus change while RW=0 and any RW=0 with CS=1 outside WR_RAM.
